axi_packet_gate: RTL and testbench
==================================

AXI_PACKET_GATE -- requirements
Module: axi_packet_gate

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning tdata width in bits.
REQ-002 SHALL have parameter SIZE, default 5, meaning log2 of buffer depth in words (32 words at default).
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous active-low reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have ports s_axis_tdata (input, WIDTH), s_axis_tlast (input, 1), s_axis_tvalid (input, 1), s_axis_tready (output, 1): input stream, fed from the clock-crossing FIFO output.
REQ-006 SHALL have port s_axis_terror, input, 1 bit: sampled on the tlast beat; 1 discards the packet.
REQ-007 SHALL have ports m_axis_tdata (output, WIDTH), m_axis_tlast (output, 1), m_axis_tvalid (output, 1), m_axis_tready (input, 1): output stream of whole packets only.
REQ-008 SHALL have port occupied, output, SIZE+1 bits: words stored, committed plus uncommitted.
REQ-009 SHALL have port pkt_count, output, SIZE+1 bits: committed packets not yet fully read.
REQ-010 SHALL have port dropped, output, 1 bit: one-cycle pulse per discarded packet.

Function
REQ-011 SHALL store words in a 2^SIZE x (WIDTH+1) memory, holding tdata and tlast.
REQ-012 SHALL keep three SIZE+1-bit pointers: wr_ptr (next write), commit_ptr (end of last committed packet), rd_ptr (next read); the MSB is the wrap bit.
REQ-013 SHALL define a transfer as tvalid && tready on the same rising clk edge.
REQ-014 SHALL run a write FSM with states WR_ACCEPT and WR_DROP.
REQ-015 In WR_ACCEPT, s_axis_tready SHALL be 1 iff (wr_ptr - rd_ptr) < 2^SIZE.
REQ-016 In WR_ACCEPT, each transfer SHALL write memory[wr_ptr] and increment wr_ptr.
REQ-017 In WR_ACCEPT, a transfer with tlast=1 and terror=0 SHALL set commit_ptr to wr_ptr+1 and increment pkt_count on that edge.
REQ-018 In WR_ACCEPT, a transfer with tlast=1 and terror=1 SHALL rewind wr_ptr to commit_ptr, leave pkt_count unchanged, and pulse dropped on the next cycle.
REQ-019 When the buffer becomes full in WR_ACCEPT with no committed words (commit_ptr == rd_ptr) and the current packet has no tlast yet, the block SHALL rewind wr_ptr to commit_ptr and go to WR_DROP.
REQ-020 In WR_DROP, s_axis_tready SHALL be 1, and data SHALL be consumed and discarded.
REQ-021 A transfer with tlast=1 in WR_DROP SHALL return the FSM to WR_ACCEPT and pulse dropped once.
REQ-022 When the buffer is full and committed words exist, the block SHALL hold s_axis_tready=0 (backpressure) and SHALL NOT drop.
REQ-023 m_axis_tvalid SHALL be 1 iff rd_ptr != commit_ptr.
REQ-024 m_axis_tdata and m_axis_tlast SHALL equal memory[rd_ptr] (first-word-fall-through).
REQ-025 A read transfer SHALL increment rd_ptr, and SHALL decrement pkt_count when m_axis_tlast=1.
REQ-026 Latency: the first beat of a packet SHALL appear on m_axis_tvalid in the cycle after its tlast beat is accepted, and never earlier.
REQ-027 A commit and a final-word read on the same edge SHALL leave pkt_count unchanged and m_axis_tvalid=1 the next cycle.
REQ-028 A single-beat packet (tlast on the first beat) SHALL be handled like any other packet.
REQ-029 occupied SHALL equal wr_ptr - rd_ptr, modulo 2^(SIZE+1).
REQ-030 m_axis_tvalid SHALL NOT depend combinationally on m_axis_tready.
REQ-031 Once asserted, m_axis_tvalid SHALL hold with stable data until the transfer completes.

Reset
REQ-032 While reset_n=0 at a clk edge, all pointers, pkt_count and dropped SHALL be cleared and the FSM SHALL enter WR_ACCEPT.
REQ-033 During reset, outputs SHALL be m_axis_tvalid=0, s_axis_tready=0, occupied=0, pkt_count=0 and dropped=0.
REQ-034 s_axis_tready SHALL go to 1 in the first cycle after reset_n returns to 1.
REQ-035 Reset asserted mid-packet SHALL discard all stored and partial packets, and SHALL NOT pulse dropped.
REQ-036 Memory contents need not be reset.

Verification
REQ-037 Scenario, basic packet: write 4 beats 1..4 with tlast on 4 and m_axis_tready=0 -> m_axis_tvalid=0 through beat 3 and 1 the cycle after beat 4; pkt_count=1; occupied=4; reading yields 1,2,3,4 with tlast only on 4.
REQ-038 Scenario, error drop: 3 beats with terror=1 on the tlast beat -> nothing output, occupied=0, exactly one dropped pulse; a following good 2-beat packet is output intact.
REQ-039 Scenario, oversize drop (SIZE=5): 40-beat packet with m_axis_tready=1 -> s_axis_tready stays 1 throughout, one dropped pulse after beat 40, no output, occupied=0 afterwards.
REQ-040 Scenario, backpressure: commit a 20-beat packet, then send a 20-beat packet with m_axis_tready=0 -> s_axis_tready=0 at occupied=32 and no drop; raising m_axis_tready drains both packets in order with correct data.
REQ-041 Scenario, boundaries: 1-beat packets back-to-back, with simultaneous commit and read of a packet's last word, for 100 packets across pointer wrap -> all data in order, pkt_count never off by one.
REQ-042 Scenario, mid-packet reset: reset_n=0 for 1 cycle after 5 beats of a 10-beat packet -> occupied=0, pkt_count=0, m_axis_tvalid=0, no dropped pulse; the next packet passes through correctly.

Source files
------------

// File: rtl/axi_packet_gate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_packet_gate : store-and-forward AXI-Stream packet buffer that releases
//                   only whole, error-free packets and drops oversize ones.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module axi_packet_gate #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] s_axis_tdata,
   input  logic             s_axis_tlast,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_terror,
   output logic [WIDTH-1:0] m_axis_tdata,
   output logic             m_axis_tlast,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [SIZE:0]    occupied,
   output logic [SIZE:0]    pkt_count,
   output logic             dropped
);

   localparam int            DEPTH       = 1 << SIZE;
   localparam logic [SIZE:0] PTR_ONE     = (SIZE+1)'(1);
   localparam logic [SIZE:0] ALMOST_FULL = (SIZE+1)'(DEPTH - 1);

   typedef enum logic [0:0] {
      WR_ACCEPT = 1'b0,
      WR_DROP   = 1'b1
   } wr_state_t;

   wr_state_t      state;
   wr_state_t      state_next;

   logic [WIDTH:0] mem [DEPTH];
   logic [WIDTH:0] rd_word;

   logic [SIZE:0]  wr_ptr;
   logic [SIZE:0]  wr_ptr_next;
   logic [SIZE:0]  commit_ptr;
   logic [SIZE:0]  commit_ptr_next;
   logic [SIZE:0]  rd_ptr;
   logic [SIZE:0]  pkt_cnt;
   logic [SIZE:0]  used;

   logic           ready_int;
   logic           valid_int;
   logic           wr_en;
   logic           commit;
   logic           drop_set;
   logic           drop_r;
   logic           rd_xfer;
   logic           rd_last;

   assign used      = wr_ptr - rd_ptr;
   assign valid_int = (rd_ptr != commit_ptr);
   assign rd_word   = mem[rd_ptr[SIZE-1:0]];
   assign rd_xfer   = valid_int && m_axis_tready;
   assign rd_last   = rd_xfer && rd_word[WIDTH];

   // Write-side FSM: next state, pointer updates and handshake
   always_comb begin
      state_next      = state;
      ready_int       = 1'b0;
      wr_en           = 1'b0;
      commit          = 1'b0;
      drop_set        = 1'b0;
      wr_ptr_next     = wr_ptr;
      commit_ptr_next = commit_ptr;
      case (state)
         WR_ACCEPT: begin
            ready_int = !used[SIZE];
            if (s_axis_tvalid && ready_int) begin
               wr_en       = 1'b1;
               wr_ptr_next = wr_ptr + PTR_ONE;
               if (s_axis_tlast) begin
                  if (s_axis_terror) begin
                     wr_ptr_next = commit_ptr;
                     drop_set    = 1'b1;
                  end else begin
                     commit          = 1'b1;
                     commit_ptr_next = wr_ptr + PTR_ONE;
                  end
               end else if (used == ALMOST_FULL && commit_ptr == rd_ptr) begin
                  // Packet alone fills the buffer and can never be released:
                  // abandon it here so the input never sees a stall.
                  wr_ptr_next = commit_ptr;
                  state_next  = WR_DROP;
               end
            end
         end
         WR_DROP: begin
            ready_int = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               drop_set   = 1'b1;
               state_next = WR_ACCEPT;
            end
         end
         default: state_next = WR_ACCEPT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= WR_ACCEPT;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         drop_r     <= 1'b0;
      end else begin
         state      <= state_next;
         wr_ptr     <= wr_ptr_next;
         commit_ptr <= commit_ptr_next;
         drop_r     <= drop_set;
         if (rd_xfer) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({commit, rd_last})
            2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
            2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[SIZE-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   // Outputs are forced idle while reset is held, before the registers clear
   assign s_axis_tready = reset_n && ready_int;
   assign m_axis_tvalid = reset_n && valid_int;
   assign m_axis_tdata  = rd_word[WIDTH-1:0];
   assign m_axis_tlast  = rd_word[WIDTH];
   assign occupied      = reset_n ? used : '0;
   assign pkt_count     = reset_n ? pkt_cnt : '0;
   assign dropped       = reset_n && drop_r;

endmodule
`default_nettype wire

// File: tb/tb_axi_packet_gate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_packet_gate : directed scoreboard bench for axi_packet_gate.
// Revision           : 1.0
// ---------------------------------------------------------------------------
module tb_axi_packet_gate;

   localparam int WIDTH = 32;
   localparam int SIZE  = 5;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] s_axis_tdata;
   logic             s_axis_tlast;
   logic             s_axis_tvalid;
   logic             s_axis_tready;
   logic             s_axis_terror;
   logic [WIDTH-1:0] m_axis_tdata;
   logic             m_axis_tlast;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic [SIZE:0]    occupied;
   logic [SIZE:0]    pkt_count;
   logic             dropped;

   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH:0]   stage_q[$];
   int               tests = 0;
   int               fails = 0;
   int               drop_cnt = 0;
   int               stall_cnt = 0;

   axi_packet_gate #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_terror (s_axis_terror),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .occupied      (occupied),
      .pkt_count     (pkt_count),
      .dropped       (dropped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: each read handshake pops the oldest expected word
   always @(negedge clk) begin
      if (dropped) drop_cnt++;
      if (reset_n && m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0)
            check("out_when_empty", 64'(m_axis_tvalid), 64'd0);
         else
            check("rd_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
      end
   end

   // Called 1ns after a rising edge; returns 1ns after the accepting edge
   task automatic send_beat(input logic [WIDTH-1:0] d, input logic last,
                            input logic err, input logic keep);
      bit done = 1'b0;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_terror = err;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (s_axis_tready) done = 1'b1;
         else stall_cnt++;
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_terror = 1'b0;
      if (!done) begin
         check("s_tready_timeout", 64'(done), 64'd1);
      end else begin
         stage_q.push_back({last, d});
         if (last) begin
            if (keep) begin
               foreach (stage_q[k]) exp_q.push_back(stage_q[k]);
            end
            stage_q.delete();
         end
      end
   endtask

   task automatic send_packet(input int base, input int len, input logic err, input logic keep);
      for (int i = 0; i < len; i++)
         send_beat(WIDTH'(base + i), (i == len - 1), err && (i == len - 1), keep);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 500 && (exp_q.size() != 0 || m_axis_tvalid); i++) begin
         @(posedge clk);
         #1;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   int d0;
   int d1;

   initial begin
      reset_n       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_terror = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_occupied", 64'(occupied), 64'd0);
      check("rst_pkt_count", 64'(pkt_count), 64'd0);
      check("rst_dropped", 64'(dropped), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_s_tready", 64'(s_axis_tready), 64'd1);

      // Basic packet: held until its last beat is in
      for (int i = 1; i <= 3; i++) begin
         send_beat(WIDTH'(i), 1'b0, 1'b0, 1'b1);
         check("basic_no_early_valid", 64'(m_axis_tvalid), 64'd0);
      end
      send_beat(WIDTH'(4), 1'b1, 1'b0, 1'b1);
      check("basic_valid", 64'(m_axis_tvalid), 64'd1);
      check("basic_pkt_count", 64'(pkt_count), 64'd1);
      check("basic_occupied", 64'(occupied), 64'd4);
      check("basic_first_word", 64'(m_axis_tdata), 64'd1);
      m_axis_tready = 1'b1;
      wait_empty();
      check("basic_pkt_after", 64'(pkt_count), 64'd0);
      check("basic_occ_after", 64'(occupied), 64'd0);

      // Error drop, then a good packet
      d0 = drop_cnt;
      send_packet(32'h50, 3, 1'b1, 1'b0);
      check("err_occupied", 64'(occupied), 64'd0);
      check("err_no_valid", 64'(m_axis_tvalid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("err_drop_pulses", 64'(drop_cnt), 64'(d0 + 1));
      send_packet(32'h60, 2, 1'b0, 1'b1);
      wait_empty();

      // Oversize packet: dropped without ever stalling the input
      d0 = drop_cnt;
      stall_cnt = 0;
      send_packet(32'h300, 40, 1'b0, 1'b0);
      check("over_no_stall", 64'(stall_cnt), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("over_drop_pulses", 64'(drop_cnt), 64'(d0 + 1));
      check("over_occupied", 64'(occupied), 64'd0);
      check("over_no_valid", 64'(m_axis_tvalid), 64'd0);
      check("over_pkt_count", 64'(pkt_count), 64'd0);

      // Backpressure with committed data present
      m_axis_tready = 1'b0;
      d0 = drop_cnt;
      send_packet(32'h1000, 20, 1'b0, 1'b1);
      check("bp_first_committed", 64'(pkt_count), 64'd1);
      fork
         send_packet(32'h2000, 20, 1'b0, 1'b1);
         begin
            for (int i = 0; i < 200 && occupied != 6'd32; i++) @(negedge clk);
            @(negedge clk);
            check("bp_occupied", 64'(occupied), 64'd32);
            check("bp_s_tready", 64'(s_axis_tready), 64'd0);
            d1 = drop_cnt;
            repeat (5) @(negedge clk);
            check("bp_no_drop", 64'(drop_cnt), 64'(d1));
            check("bp_hold_ready", 64'(s_axis_tready), 64'd0);
            @(posedge clk);
            #1;
            m_axis_tready = 1'b1;
         end
      join
      wait_empty();
      check("bp_total_drops", 64'(drop_cnt), 64'(d0));
      check("bp_pkt_after", 64'(pkt_count), 64'd0);

      // Single-beat packets: commit and last-word read share an edge
      for (int i = 0; i < 100; i++) begin
         send_beat(WIDTH'(32'h7000 + i), 1'b1, 1'b0, 1'b1);
         check("one_beat_pkt_count", 64'(pkt_count), 64'd1);
         check("one_beat_valid", 64'(m_axis_tvalid), 64'd1);
      end
      wait_empty();
      check("one_beat_pkt_after", 64'(pkt_count), 64'd0);

      // Reset in the middle of a packet
      m_axis_tready = 1'b0;
      send_packet(32'h9000, 3, 1'b0, 1'b1);
      d0 = drop_cnt;
      for (int i = 0; i < 5; i++) send_beat(WIDTH'(32'hA000 + i), 1'b0, 1'b0, 1'b1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
      reset_n = 1'b1;
      exp_q.delete();
      stage_q.delete();
      check("mid_rst_occupied", 64'(occupied), 64'd0);
      check("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
      check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_no_drop", 64'(drop_cnt), 64'(d0));
      m_axis_tready = 1'b1;
      send_packet(32'hB000, 3, 1'b0, 1'b1);
      wait_empty();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
